// File: rtl/alu_operand_issue.sv
// Operand issue stage: buffers (A,B) pairs in a small FIFO and paces them into the ALU.
// Optional stats counters are enabled with the ALU_OPERAND_ISSUE_STATS_EN macro.
module alu_operand_issue #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 2
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Flush,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [WIDTH-1:0]         InA,
    input  logic [WIDTH-1:0]         InB,
    output logic [WIDTH-1:0]         ArgA,
    output logic [WIDTH-1:0]         ArgB,
    output logic                     ArgValid,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
    output logic                     Full
`ifdef ALU_OPERAND_ISSUE_STATS_EN
    ,
    output logic [31:0]              IssueCnt,
    output logic [31:0]              StallCnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (ISSUE_GAP < 2) ? 1 : $clog2(ISSUE_GAP + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    logic [AW:0]          wptr_q, wptr_d;
    logic [AW:0]          rptr_q, rptr_d;
    logic [2*WIDTH-1:0]   mem_q [DEPTH];
    logic [2*WIDTH-1:0]   mem_d [DEPTH];
    state_t               state_q, state_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [WIDTH-1:0]     arg_a_q, arg_a_d;
    logic [WIDTH-1:0]     arg_b_q, arg_b_d;
    logic                 arg_valid_q, arg_valid_d;
    logic                 push;
    logic                 pop;

    assign Count    = wptr_q - rptr_q;
    assign Empty    = (wptr_q == rptr_q);
    assign Full     = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign InReady  = !Full;
    assign ArgA     = arg_a_q;
    assign ArgB     = arg_b_q;
    assign ArgValid = arg_valid_q;

    assign push = InValid && !Full && !Flush;
    assign pop  = (state_q == IDLE) && !Empty && !Flush;

    // FIFO write and pointer advance; flush empties the queue
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = rptr_q + (AW+1)'(pop);
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = {InA, InB};
        end
        if (Flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    // Issue FSM: pop into the ALU operand registers, then wait out the gap
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        arg_a_d     = arg_a_q;
        arg_b_d     = arg_b_q;
        arg_valid_d = 1'b0;
        if (Flush) begin
            state_d = IDLE;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        {arg_a_d, arg_b_d} = mem_q[rptr_q[AW-1:0]];
                        arg_valid_d        = 1'b1;
                        if (ISSUE_GAP > 0) begin
                            state_d = HOLD;
                            gap_d   = GW'(ISSUE_GAP);
                        end
                    end
                end
                HOLD: begin
                    if (gap_q <= GW'(1)) begin
                        gap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and operand registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            state_q     <= IDLE;
            gap_q       <= '0;
            arg_a_q     <= '0;
            arg_b_q     <= '0;
            arg_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            state_q     <= state_d;
            gap_q       <= gap_d;
            arg_a_q     <= arg_a_d;
            arg_b_q     <= arg_b_d;
            arg_valid_q <= arg_valid_d;
        end
    end

    // FIFO storage needs no reset; entries are only read after being written
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

`ifdef ALU_OPERAND_ISSUE_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign IssueCnt = issue_cnt_q;
    assign StallCnt = stall_cnt_q;

    // Count issued pairs and rejected pushes; both freeze during flush
    always_comb begin
        issue_cnt_d = issue_cnt_q + 32'(pop);
        stall_cnt_d = stall_cnt_q + 32'(InValid && !InReady && !Flush);
    end

    // Stats registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue (default parameters).
// Directed table, hand sequences and random stimulus against a queue model.
module tb_alu_operand_issue;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic        Clk;
    logic        Rst_n;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [31:0] InA;
    logic [31:0] InB;
    logic [31:0] ArgA;
    logic [31:0] ArgB;
    logic        ArgValid;
    logic [2:0]  Count;
    logic        Empty;
    logic        Full;
`ifdef ALU_OPERAND_ISSUE_STATS_EN
    logic [31:0] IssueCnt;
    logic [31:0] StallCnt;
`endif

    alu_operand_issue #(.WIDTH(32), .DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB),
        .ArgA(ArgA), .ArgB(ArgB), .ArgValid(ArgValid),
        .Count(Count), .Empty(Empty), .Full(Full)
`ifdef ALU_OPERAND_ISSUE_STATS_EN
        , .IssueCnt(IssueCnt), .StallCnt(StallCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] mq[$];
    int          cool;
    logic [31:0] m_a, m_b;
    logic        m_av;
    logic [31:0] m_ic, m_sc;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step(input string name, input logic rst_n, input logic fl,
                        input logic v, input logic [31:0] a,
                        input logic [31:0] b);
        int   n;
        logic full;
        Rst_n   = rst_n;
        Flush   = fl;
        InValid = v;
        InA     = a;
        InB     = b;
        @(posedge Clk);
        if (!rst_n) begin
            mq.delete();
            cool = 0; m_a = 0; m_b = 0; m_av = 0; m_ic = 0; m_sc = 0;
        end else if (fl) begin
            mq.delete();
            cool = 0; m_av = 0;
        end else begin
            n    = mq.size();
            full = (n == DEPTH);
            if (v && full) m_sc++;
            if (cool == 0 && n > 0) begin
                {m_a, m_b} = mq.pop_front();
                m_av = 1; m_ic++; cool = GAP;
            end else begin
                m_av = 0;
                if (cool > 0) cool--;
            end
            if (v && !full) mq.push_back({a, b});
        end
        #1;
        chk(name,
            128'({ArgValid, Count, Empty, Full, InReady, ArgA, ArgB}),
            128'({m_av, 3'(mq.size()), mq.size() == 0, mq.size() == DEPTH,
                  mq.size() != DEPTH, m_a, m_b}));
`ifdef ALU_OPERAND_ISSUE_STATS_EN
        chk({name, "_stats"}, 128'({IssueCnt, StallCnt}), 128'({m_ic, m_sc}));
`endif
    endtask

    typedef struct {
        logic        rst_n, fl, v;
        logic [31:0] a, b;
        logic        e_av;
        logic [2:0]  e_cnt;
        logic        e_full, e_ready;
        logic [31:0] e_a, e_b;
    } vec_t;

    vec_t        tbl[5];
    int          pulses[$];
    logic [63:0] sent[$];
    logic [63:0] got[$];
    logic [31:0] va[4];
    logic [31:0] vb[4];
    logic [31:0] keep_a, keep_b;
    int          pc, idx;

    initial begin
        Rst_n = 0; Flush = 0; InValid = 0; InA = 0; InB = 0;
        cool = 0; m_a = 0; m_b = 0; m_av = 0; m_ic = 0; m_sc = 0;

        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{1, 0, 1, 32'h01234567, 32'h89abcdef,
                   0, 1, 0, 1, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 0,
                   1, 0, 0, 1, 32'h01234567, 32'h89abcdef};
        tbl[3] = '{1, 0, 0, 0, 0,
                   0, 0, 0, 1, 32'h01234567, 32'h89abcdef};
        tbl[4] = tbl[3];
        for (int i = 0; i < 5; i++) begin
            step("tbl_model", tbl[i].rst_n, tbl[i].fl, tbl[i].v,
                 tbl[i].a, tbl[i].b);
            chk($sformatf("tbl_%0d", i),
                128'({ArgValid, Count, Full, InReady, ArgA, ArgB}),
                128'({tbl[i].e_av, tbl[i].e_cnt, tbl[i].e_full,
                      tbl[i].e_ready, tbl[i].e_a, tbl[i].e_b}));
        end

        va = '{32'h80000000, 32'h80000000, 32'h7fffffff, 32'h00000000};
        vb = '{32'h80000000, 32'h7fffffff, 32'h7fffffff, 32'hffffffff};
        pulses.delete();
        for (int i = 0; i < 16; i++) begin
            if (i < 4) step("b2b", 1, 0, 1, va[i], vb[i]);
            else       step("b2b", 1, 0, 0, 0, 0);
            if (ArgValid) pulses.push_back(i);
        end
        chk("b2b_pulses", 128'(pulses.size()), 128'(4));
        for (int i = 1; i < pulses.size(); i++)
            chk("b2b_spacing", 128'(pulses[i] - pulses[i-1]), 128'(GAP + 1));

        pc = 0;
        for (int i = 0; i < 21; i++) begin
            if (i < 7) step("fill", 1, 0, 1, 32'hA000 + i, 32'hB000 + i);
            else       step("drain", 1, 0, 0, 0, 0);
            if (ArgValid) pc++;
        end
        chk("fill_pulses", 128'(pc), 128'(6));
        chk("fill_empty", 128'(Empty), 128'(1));

        sent.delete(); got.delete(); idx = 0;
        for (int i = 0; i < 80 && got.size() < 10; i++) begin
            if (idx < 10 && mq.size() < DEPTH) begin
                sent.push_back({32'hC00 + idx, 32'hD00 + idx});
                step("wrap", 1, 0, 1, 32'hC00 + idx, 32'hD00 + idx);
                idx++;
            end else begin
                step("wrap", 1, 0, 0, 0, 0);
            end
            if (ArgValid) got.push_back({ArgA, ArgB});
        end
        chk("wrap_count", 128'(got.size()), 128'(10));
        for (int i = 0; i < got.size() && i < sent.size(); i++)
            chk("wrap_order", 128'(got[i]), 128'(sent[i]));

        step("flush_rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("flush_fill", 1, 0, 1, 32'hE0 + i, 32'hF0 + i);
        chk("flush_pre", 128'(Count), 128'(3));
        keep_a = ArgA; keep_b = ArgB;
        step("flush", 1, 1, 1, 32'h5555, 32'h6666);
        chk("flush_post",
            128'({Count, Empty, ArgValid, ArgA, ArgB}),
            128'({3'd0, 1'b1, 1'b0, keep_a, keep_b}));
        for (int i = 0; i < 3; i++) step("flush_idle", 1, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++)
            step("mid_rst_fill", 1, 0, 1, 32'h1111 * i, 32'h2222 * i);
        step("mid_rst", 0, 0, 1, 32'h77, 32'h88);
        chk("mid_rst_vals",
            128'({ArgA, ArgB, ArgValid, Count, Empty, Full, InReady}),
            128'({32'h0, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1}));

        for (int i = 0; i < 500; i++)
            step("rand", $urandom_range(0, 99) != 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                 $urandom, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
